sharpen_filter: RTL and testbench



---
 rtl/sharpen_filter_if.sv | 28 ++
 rtl/sharpen_filter.sv | 189 ++++++++++++++++++
 tb/tb_sharpen_filter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sharpen_filter_if.sv
// Bundle of the sharpen stage's control and memory-port signals.
// master: the filter (drives read/write addresses, write data, done).
// slave: the surrounding pipeline (drives start and the source pixel).
// Ports: start, filter_done, rd_row/rd_col/in_pix (source read port),
//        wr_row/wr_col/out_we/out_pix (destination write port).
interface sharpen_filter_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic [ADDR_W-1:0] rd_row;
    logic [ADDR_W-1:0] rd_col;
    logic [23:0]       in_pix;
    logic [ADDR_W-1:0] wr_row;
    logic [ADDR_W-1:0] wr_col;
    logic              out_we;
    logic [23:0]       out_pix;
    logic              filter_done;

    modport master (
        input  start, in_pix,
        output rd_row, rd_col, wr_row, wr_col, out_we, out_pix, filter_done
    );

    modport slave (
        output start, in_pix,
        input  rd_row, rd_col, wr_row, wr_col, out_we, out_pix, filter_done
    );
endinterface

// File: rtl/sharpen_filter.sv
// Purpose: 3x3 sharpen (centre 9, neighbours -1) over the G channel of a source image.
// Latency: fixed 10 cycles per pixel (9 tap reads + 1 write); whole image in 10*4^ADDR_W cycles.
// Backpressure: none; the source read port is combinational and the destination always accepts.
// Ports: clk, rst (synchronous, active-high); bus (sharpen_filter_if.master) carries
//        start/filter_done plus the source read port and the destination write port.
// Option: define SHARPEN_BORDER_COPY_EN to copy border pixels' centre G unchanged
//         instead of zero-padding the kernel at the image edge.
// ADDR_W must match the parameter of the connected interface instance.
module sharpen_filter #(
    parameter int ADDR_W = 6
) (
    input logic              clk,
    input logic              rst,
    sharpen_filter_if.master bus
);

    typedef enum logic [1:0] {IDLE, TAP, WRITE, DONE} state_t;

    localparam logic [ADDR_W-1:0] MAX_IDX = '1;
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    state_t state, state_nx;

    // Centre pixel coordinates and 3x3 tap position (tap_r/tap_c = dr+1 / dc+1).
    logic [ADDR_W-1:0] row, col;
    logic [1:0]        tap_r, tap_c;
    logic signed [12:0] acc;

    logic [ADDR_W-1:0] wr_row_q, wr_col_q;
    logic              out_we_q;
    logic [23:0]       out_pix_q;
    logic              done_q;

    logic              first_tap, centre_tap, last_tap, last_pix;
    logic              row_oob, col_oob, tap_in;
    logic [ADDR_W-1:0] tap_row, tap_col;
    logic [ADDR_W-1:0] rd_row_c, rd_col_c;
    logic [7:0]        g;
    logic signed [12:0] g_ext, contrib, acc_base, acc_sum;
    logic [7:0]        y_clamp, y_out;

    // R and B channels of the source are don't-care.
    logic unused_rb;
    assign unused_rb = ^{bus.in_pix[23:16], bus.in_pix[7:0]};

    assign first_tap  = (tap_r == 2'd0) && (tap_c == 2'd0);
    assign centre_tap = (tap_r == 2'd1) && (tap_c == 2'd1);
    assign last_tap   = (tap_r == 2'd2) && (tap_c == 2'd2);
    assign last_pix   = (row == MAX_IDX) && (col == MAX_IDX);

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = TAP;
            TAP:     if (last_tap)  state_nx = WRITE;
            WRITE:   state_nx = last_pix ? DONE : TAP;
            DONE:    if (bus.start) state_nx = TAP;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Tap addressing: a tap that falls outside the image parks the read
    // address on the centre pixel and contributes nothing (no wrap).
    // ---------------------------------------------------------------
    always_comb begin
        row_oob = ((tap_r == 2'd0) && (row == '0)) || ((tap_r == 2'd2) && (row == MAX_IDX));
        col_oob = ((tap_c == 2'd0) && (col == '0)) || ((tap_c == 2'd2) && (col == MAX_IDX));
        tap_in  = !row_oob && !col_oob;

        tap_row = row;
        if (tap_r == 2'd0)      tap_row = row - ONE;
        else if (tap_r == 2'd2) tap_row = row + ONE;

        tap_col = col;
        if (tap_c == 2'd0)      tap_col = col - ONE;
        else if (tap_c == 2'd2) tap_col = col + ONE;

        rd_row_c = '0;
        rd_col_c = '0;
        if (state == TAP) begin
            rd_row_c = tap_in ? tap_row : row;
            rd_col_c = tap_in ? tap_col : col;
        end
    end

    // ---------------------------------------------------------------
    // Accumulate: centre adds 9*G (as 8G+G), neighbours subtract G.
    // The first tap restarts from zero so no separate clear cycle is needed.
    // ---------------------------------------------------------------
    always_comb begin
        g        = bus.in_pix[15:8];
        g_ext    = $signed({5'b0, g});
        contrib  = '0;
        if (tap_in) contrib = centre_tap ? ((g_ext <<< 3) + g_ext) : -g_ext;
        acc_base = first_tap ? 13'sd0 : acc;
        acc_sum  = acc_base + contrib;

        if (acc_sum[12])              y_clamp = 8'd0;
        else if (acc_sum > 13'sd255)  y_clamp = 8'd255;
        else                          y_clamp = acc_sum[7:0];
    end

`ifdef SHARPEN_BORDER_COPY_EN
    logic [7:0] centre_g;
    logic       is_border;
    assign is_border = (row == '0) || (row == MAX_IDX) || (col == '0) || (col == MAX_IDX);
    assign y_out     = is_border ? centre_g : y_clamp;

    // Centre G captured on the centre tap, used at the last tap for border pixels.
    always_ff @(posedge clk) begin
        if (rst)                                centre_g <= '0;
        else if ((state == TAP) && centre_tap)  centre_g <= g;
    end
`else
    assign y_out = y_clamp;
`endif

    // ---------------------------------------------------------------
    // Datapath / outputs. The write port is loaded on the edge that ends
    // the last tap, so out_we is high exactly while the FSM sits in WRITE.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            row       <= '0;
            col       <= '0;
            tap_r     <= '0;
            tap_c     <= '0;
            acc       <= '0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            out_we_q  <= 1'b0;
            out_pix_q <= '0;
            done_q    <= 1'b0;
        end else begin
            out_we_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        row    <= '0;
                        col    <= '0;
                        tap_r  <= '0;
                        tap_c  <= '0;
                        done_q <= 1'b0;
                    end
                end
                TAP: begin
                    acc <= acc_sum;
                    if (last_tap) begin
                        tap_r     <= '0;
                        tap_c     <= '0;
                        out_we_q  <= 1'b1;
                        wr_row_q  <= row;
                        wr_col_q  <= col;
                        out_pix_q <= {8'h00, y_out, 8'h00};
                    end else if (tap_c == 2'd2) begin
                        tap_c <= '0;
                        tap_r <= tap_r + 2'd1;
                    end else begin
                        tap_c <= tap_c + 2'd1;
                    end
                end
                WRITE: begin
                    // Raster advance: column first, carry into row.
                    {row, col} <= {row, col} + {{ADDR_W{1'b0}}, ONE};
                    if (last_pix) done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_row      = rd_row_c;
    assign bus.rd_col      = rd_col_c;
    assign bus.wr_row      = wr_row_q;
    assign bus.wr_col      = wr_col_q;
    assign bus.out_we      = out_we_q;
    assign bus.out_pix     = out_pix_q;
    assign bus.filter_done = done_q;

endmodule

// File: tb/tb_sharpen_filter.sv
// Bench for sharpen_filter at ADDR_W=6: source image held in an array and read
// combinationally, writes captured per cycle and compared with a direct
// neighbourhood-sum model of the kernel.
module tb_sharpen_filter;

    localparam int AW = 6;
    localparam int N  = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sharpen_filter_if #(.ADDR_W(AW)) bus ();

    logic [23:0] src [0:N-1][0:N-1];
    assign bus.in_pix = src[bus.rd_row][bus.rd_col];

    sharpen_filter #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Captured writes of the last collect() call.
    int          q_cyc [$];
    int          q_r   [$];
    int          q_c   [$];
    logic [23:0] q_p   [$];
    int          done_at;
    logic [49:0] snap;

    // Expected Y from the kernel definition: plain sum over the in-range
    // 3x3 neighbourhood, then clamp to 0..255.
    function automatic int model_y(int r, int c);
        int s;
        s = 0;
`ifdef SHARPEN_BORDER_COPY_EN
        if (r == 0 || c == 0 || r == N-1 || c == N-1) return int'(src[r][c][15:8]);
`endif
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                int rr, cc, gv;
                rr = r + dr;
                cc = c + dc;
                if (rr >= 0 && rr < N && cc >= 0 && cc < N) begin
                    gv = int'(src[rr][cc][15:8]);
                    s += (dr == 0 && dc == 0) ? 9 * gv : -gv;
                end
            end
        end
        if (s < 0)   s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    // Runs from a negedge: pulses start sampled at edge 0, optionally pulses
    // start again at edge restart_at and rst at edge rst_at. An observation
    // made at the negedge before edge k is logged as cycle k.
    task automatic collect(input int ncyc, input int restart_at, input int rst_at);
        q_cyc.delete(); q_r.delete(); q_c.delete(); q_p.delete();
        done_at = -1;
        snap    = '1;
        for (int k = 0; k <= ncyc; k++) begin
            if (k >= 1) begin
                if (bus.out_we === 1'b1) begin
                    q_cyc.push_back(k);
                    q_r.push_back(int'(bus.wr_row));
                    q_c.push_back(int'(bus.wr_col));
                    q_p.push_back(bus.out_pix);
                end
                if (bus.filter_done === 1'b1 && done_at < 0) done_at = k;
                if (k == rst_at + 1)
                    snap = {bus.rd_row, bus.rd_col, bus.wr_row, bus.wr_col,
                            bus.out_we, bus.out_pix, bus.filter_done};
            end
            bus.start = (k == 0) || (k == restart_at);
            rst       = (k == rst_at);
            @(negedge clk);
        end
        bus.start = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_random();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                src[r][c] = 24'($urandom);
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.rd_row, bus.rd_col} !== '0) begin
            n_fail++;
            $display("FAIL reset_rd: got row=%0d col=%0d, want 0 0", bus.rd_row, bus.rd_col);
        end
        n_tests++;
        if ({bus.wr_row, bus.wr_col, bus.out_we, bus.out_pix} !== '0) begin
            n_fail++;
            $display("FAIL reset_wr: got row=%0d col=%0d we=%b pix=%h, want all 0",
                     bus.wr_row, bus.wr_col, bus.out_we, bus.out_pix);
        end
        n_tests++;
        if (bus.filter_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got %b, want 0", bus.filter_done);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Uniform G=100; second variant sets R=B=FF to show channel isolation.
    task automatic test_uniform();
        for (int v = 0; v < 2; v++) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    src[r][c] = (v == 1) ? 24'hFF64FF : 24'h006400;
            collect(700, -1, -1);
            n_tests++;
            if (q_cyc.size() != 70) begin
                n_fail++;
                $display("FAIL uniform%0d_count: got %0d writes, want 70", v, q_cyc.size());
            end
            for (int i = 0; i < q_cyc.size(); i++) begin
                int r, c, y;
                logic [23:0] ep;
                r = i / N;
                c = i % N;
`ifdef SHARPEN_BORDER_COPY_EN
                y = 100;
`else
                y = (r == 0 || c == 0 || r == N-1 || c == N-1) ? 255 : 100;
`endif
                ep = {8'h00, 8'(y), 8'h00};
                n_tests++;
                if (q_cyc[i] != 10 + 10*i || q_r[i] != r || q_c[i] != c || q_p[i] !== ep) begin
                    n_fail++;
                    $display("FAIL uniform%0d_px%0d: got cyc=%0d (%0d,%0d) pix=%h, want cyc=%0d (%0d,%0d) pix=%h",
                             v, i, q_cyc[i], q_r[i], q_c[i], q_p[i], 10 + 10*i, r, c, ep);
                end
            end
            do_reset();
        end
    endtask

    // Single bright pixel at (10,10) on a black G plane; R/B random.
    task automatic test_impulse();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                src[r][c] = {8'($urandom), 8'h00, 8'($urandom)};
        src[10][10][15:8] = 8'hFF;
        collect(7200, -1, -1);
        n_tests++;
        if (q_cyc.size() != 720) begin
            n_fail++;
            $display("FAIL impulse_count: got %0d writes, want 720", q_cyc.size());
        end
        for (int i = 0; i < q_cyc.size(); i++) begin
            int r, c;
            logic [23:0] ep;
            r  = i / N;
            c  = i % N;
            ep = (r == 10 && c == 10) ? 24'h00FF00 : 24'h000000;
            n_tests++;
            if (q_cyc[i] != 10 + 10*i || q_r[i] != r || q_c[i] != c || q_p[i] !== ep) begin
                n_fail++;
                $display("FAIL impulse_px%0d: got cyc=%0d (%0d,%0d) pix=%h, want cyc=%0d (%0d,%0d) pix=%h",
                         i, q_cyc[i], q_r[i], q_c[i], q_p[i], 10 + 10*i, r, c, ep);
            end
        end
        do_reset();
    endtask

    // Extra start at cycle 500 is ignored; rst at 2000 aborts; new start restarts at (0,0).
    task automatic test_robustness();
        int late;
        fill_random();
        collect(2100, 500, 2000);
        late = 0;
        for (int i = 0; i < q_cyc.size(); i++) if (q_cyc[i] > 2000) late++;
        n_tests++;
        if (q_cyc.size() - late != 200) begin
            n_fail++;
            $display("FAIL robust_count: got %0d writes up to rst, want 200", q_cyc.size() - late);
        end
        n_tests++;
        if (late != 0) begin
            n_fail++;
            $display("FAIL robust_after_rst: got %0d writes after rst, want 0", late);
        end
        n_tests++;
        if (snap !== '0) begin
            n_fail++;
            $display("FAIL robust_rst_outputs: got %h, want all 0", snap);
        end
        for (int i = 0; i < q_cyc.size() - late; i++) begin
            int r, c;
            logic [23:0] ep;
            r  = i / N;
            c  = i % N;
            ep = {8'h00, 8'(model_y(r, c)), 8'h00};
            n_tests++;
            if (q_cyc[i] != 10 + 10*i || q_r[i] != r || q_c[i] != c || q_p[i] !== ep) begin
                n_fail++;
                $display("FAIL robust_px%0d: got cyc=%0d (%0d,%0d) pix=%h, want cyc=%0d (%0d,%0d) pix=%h",
                         i, q_cyc[i], q_r[i], q_c[i], q_p[i], 10 + 10*i, r, c, ep);
            end
        end
        // Restart from IDLE after the abort.
        collect(30, -1, -1);
        n_tests++;
        if (q_cyc.size() != 3 || q_cyc[0] != 10 || q_r[0] != 0 || q_c[0] != 0 ||
            q_p[0] !== {8'h00, 8'(model_y(0, 0)), 8'h00}) begin
            n_fail++;
            $display("FAIL robust_restart: got %0d writes first cyc=%0d (%0d,%0d) pix=%h, want 3 writes first cyc=10 (0,0) pix=%h",
                     q_cyc.size(), (q_cyc.size() > 0) ? q_cyc[0] : -1,
                     (q_r.size() > 0) ? q_r[0] : -1, (q_c.size() > 0) ? q_c[0] : -1,
                     (q_p.size() > 0) ? q_p[0] : 24'hx, {8'h00, 8'(model_y(0, 0)), 8'h00});
        end
        do_reset();
    endtask

    // Whole random image: schedule, every pixel value, and done timing.
    task automatic test_full_pass();
        fill_random();
        collect(41000, -1, -1);
        n_tests++;
        if (q_cyc.size() != N*N) begin
            n_fail++;
            $display("FAIL full_count: got %0d writes, want %0d", q_cyc.size(), N*N);
        end
        n_tests++;
        if (done_at != 40961) begin
            n_fail++;
            $display("FAIL full_done_cycle: got %0d, want 40961", done_at);
        end
        n_tests++;
        if (bus.filter_done !== 1'b1) begin
            n_fail++;
            $display("FAIL full_done_held: got %b, want 1", bus.filter_done);
        end
        for (int i = 0; i < q_cyc.size(); i++) begin
            int r, c;
            logic [23:0] ep;
            r  = i / N;
            c  = i % N;
            ep = {8'h00, 8'(model_y(r, c)), 8'h00};
            n_tests++;
            if (q_cyc[i] != 10 + 10*i || q_r[i] != r || q_c[i] != c || q_p[i] !== ep) begin
                n_fail++;
                $display("FAIL full_px%0d: got cyc=%0d (%0d,%0d) pix=%h, want cyc=%0d (%0d,%0d) pix=%h",
                         i, q_cyc[i], q_r[i], q_c[i], q_p[i], 10 + 10*i, r, c, ep);
            end
        end
    endtask

    // Start from DONE (no reset): done clears at once, pass restarts at (0,0).
    task automatic test_restart_from_done();
        collect(20, -1, -1);
        n_tests++;
        if (done_at != -1) begin
            n_fail++;
            $display("FAIL done_restart_clear: done seen at cycle %0d, want never", done_at);
        end
        n_tests++;
        if (q_cyc.size() != 2 || q_cyc[0] != 10 || q_r[0] != 0 || q_c[0] != 0 ||
            q_p[0] !== {8'h00, 8'(model_y(0, 0)), 8'h00}) begin
            n_fail++;
            $display("FAIL done_restart_first: got %0d writes first cyc=%0d (%0d,%0d), want 2 writes first cyc=10 (0,0)",
                     q_cyc.size(), (q_cyc.size() > 0) ? q_cyc[0] : -1,
                     (q_r.size() > 0) ? q_r[0] : -1, (q_c.size() > 0) ? q_c[0] : -1);
        end
        do_reset();
    endtask

    initial begin
        bus.start = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                src[r][c] = '0;
        test_reset();
        test_uniform();
        test_impulse();
        test_robustness();
        test_full_pass();
        test_restart_from_done();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
